led7_scan_ctrl: RTL and testbench
=================================

// Module: led7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//  Holds NUM_DIGITS BCD values and cycles one active-low anode at a time.
//  Drives each digit's value through one shared led7_anode9 decoder instance.
//  Inserts a dead-time blank between digits (anti-ghosting); commits new values
//  only at frame boundaries, so a frame never mixes old and new digits.
// PARAMETERS
//  NUM_DIGITS  4      number of digits / anode lines (2..8)
//  SLOT_CYC    50000  clock cycles per digit slot, blank included (> BLANK_CYC)
//  BLANK_CYC   16     dead-time cycles at the start of every slot (>= 1)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous active-low reset
//  load        in   1             1-cycle strobe: capture din into shadow register
//  din         in   4*NUM_DIGITS  BCD digits; digit k = din[4k+3:4k]; k=0 rightmost
//  pending     out  1             shadow holds data not yet committed
//  frame_tick  out  1             1-cycle pulse at every frame-boundary commit point
//  an          out  NUM_DIGITS    anode enables, active-low, one-hot-low or all 1
//  seg         out  7             segments {a..g}, active-low (led7_anode9 coding)
// BEHAVIOUR
//  - Reset (async assert, sync release): an=all 1, seg=7'b1111111, pending=0,
//    frame_tick=0, idx=0, state=BLANK, slot counter=0, active digits=4'hF (dark).
//  - FSM per slot: BLANK for BLANK_CYC cycles (an all 1, seg 7'h7F), then
//    ON for SLOT_CYC-BLANK_CYC cycles (an[idx]=0, seg=decode(active[idx])).
//  - an/seg are registers; they take the new state's values on the same edge
//    that enters the state. There is no combinational path from din to outputs.
//  - Slot end (last ON cycle): idx <= idx+1; NUM_DIGITS-1 wraps to 0 = frame end.
//  - Frame end: frame_tick=1 for that cycle. If pending=1: active<=shadow and
//    pending<=0. Otherwise active is unchanged.
//  - load=1: shadow<=din, pending<=1. The last load before a frame end wins.
//  - load at the frame-end cycle: the old shadow commits; the new din enters
//    the shadow; pending stays 1 (the new data commits at the next frame end).
//  - Digit value 4'hA..4'hF: seg=7'b1111111 while an[idx] is still driven low.
//  - Frame period = NUM_DIGITS*SLOT_CYC cycles. Counters wrap, no overflow state.
//  - rst_n low in any state: outputs go to reset values immediately. The scan
//    restarts at digit 0 BLANK with a dark display; the shadow is discarded.
// CONFIGURATION
//  LED7_LZB_EN defined: leading-zero blanking. Digit k (k>=1) with value 0 shows
//    7'b1111111 if all active digits above k are also 0. Digit 0 always shows.
//  LED7_LZB_EN undefined: every digit is decoded as is (zeros show 7'b0000001).
// TESTING (NUM_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2)
//  1 rst_n=0 mid-ON -> an=4'b1111, seg=7'b1111111, pending=0 that same cycle.
//  2 load din=16'h1234 -> pending=1 until frame_tick. Next frame, digit0 ON:
//    an=4'b1110, seg=7'b1001100. Digit3 ON: an=4'b0111, seg=7'b1001111.
//    Each digit: 2 blank cycles, then 6 ON cycles. Frame = 32 cycles.
//  3 load 16'h1111 then 16'h5678 within one frame -> 1111 never displayed.
//    Load 16'h9999 on the frame_tick cycle -> 5678 commits; 9999 shows next frame.
//  4 din=16'h00A0 -> digit1 slot: an=4'b1101, seg=7'b1111111.
//  5 din=16'h0007 -> with LED7_LZB_EN: digits3..1 seg=7'h7F, digit0 seg=7'b0001111.
//    Without the macro: digits3..1 seg=7'b0000001. din=16'h0000 with macro ->
//    digit0 seg=7'b0000001.
//  6 Check every cycle: an never has two bits low. No digit changes value
//    within a frame (compare against a frame-latched model).

Source files
------------

// File: rtl/led7_scan_ctrl.sv
// led7_anode9: BCD to active-low {a..g} segment decoder; values A..F are dark.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module led7_anode9 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// led7_scan_ctrl: multiplexed scan of NUM_DIGITS BCD digits through one shared decoder, with per-slot dead time.
// Latency: an/seg are registered; a loaded value first appears in the frame after the next frame boundary.
// Backpressure: none; load is always accepted and the last load before a frame end wins. LED7_LZB_EN: leading-zero blanking.
module led7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [IW-1:0]              idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0] active;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic                       frame_end;
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic [3:0]                 dec_bcd;
  logic [6:0]                 dec_seg;
  logic [NUM_DIGITS-1:0]      an_d;
  logic [6:0]                 seg_d;

  // Slot counter runs across the whole slot; blank occupies its first BLANK_CYC counts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (cnt == SLOT_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            frame_end = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

`ifdef LED7_LZB_EN
  // A zero is blanked only while every digit above it is also zero.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    lz_blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above & (active[k] == 4'd0);
      lz_blank[k] = zeros_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign dec_bcd = lz_blank[idx_nxt] ? 4'hF : active[idx_nxt];

  led7_anode9 u_dec (
    .bcd (dec_bcd),
    .seg (dec_seg)
  );

  // Output registers load the values of the state being entered.
  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    if (state_nxt == ST_ON) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_d = dec_seg;
    end
  end

  assign frame_tick = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= '0;
      active  <= '1;
      shadow  <= '1;
      pending <= 1'b0;
      an      <= '1;
      seg     <= 7'b1111111;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      an    <= an_d;
      seg   <= seg_d;
      if (frame_end && pending) begin
        active <= shadow;
      end
      // A load on the frame-end cycle keeps pending set for the next frame.
      if (load) begin
        shadow  <= din;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Bench for led7_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blank): table vectors plus scoreboard of per-slot an/seg.
module tb_led7_scan_ctrl;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SC;

`ifdef LED7_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   din = 16'h0000;
  logic          pending;
  logic          frame_tick;
  logic [3:0]    an;
  logic [6:0]    seg;

  led7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SLOT_CYC   (SC),
    .BLANK_CYC  (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .din        (din),
    .pending    (pending),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  typedef struct {
    logic [15:0]     din;
    logic [3:0][6:0] segs;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  slot_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0][6:0] segs);
    for (int k = 0; k < ND; k++) begin
      slot_t s;
      s.an  = ~(4'b0001 << k);
      s.seg = segs[k];
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_wait", frame_tick, 1);
  endtask

  // Called at the negedge of the first cycle of a frame; returns on its last cycle.
  task automatic check_frame(input logic pend_first);
    slot_t cur;
    int    s;
    int    off;
    cur.an  = 4'hF;
    cur.seg = 7'h7F;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      s   = c / SC;
      off = c % SC;
      chk("an_single_low", ($countones(~an) <= 1), 1);
      chk($sformatf("frame_tick c%0d", c), frame_tick, (c == FRAME - 1));
      if (c == 0) chk("pending_frame_start", pending, pend_first);
      if (off < BC) begin
        chk($sformatf("blank_an d%0d", s), an, 4'hF);
        chk($sformatf("blank_seg d%0d", s), seg, 7'h7F);
      end else begin
        if (off == BC) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: actual=0 required=1");
            cur.an  = 4'hF;
            cur.seg = 7'h7F;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk($sformatf("on_an d%0d", s), an, cur.an);
        chk($sformatf("on_seg d%0d", s), seg, cur.seg);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{din: 16'h1234, segs: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vt[1] = '{din: 16'h5678, segs: {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}};
    vt[2] = '{din: 16'h00A0, segs: {LZ, LZ, 7'b1111111, 7'b0000001}};
    vt[3] = '{din: 16'h0007, segs: {LZ, LZ, LZ, 7'b0001111}};
    vt[4] = '{din: 16'h9F09, segs: {7'b0000100, 7'b1111111, 7'b0000001, 7'b0000100}};
    vt[5] = '{din: 16'h0000, segs: {LZ, LZ, LZ, 7'b0000001}};
    vt[6] = '{din: 16'h0800, segs: {LZ, 7'b0000000, 7'b0000001, 7'b0000001}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_pending", pending, 0);
    chk("reset_frame_tick", frame_tick, 0);

    // First frame after reset is dark with anodes still scanning
    rst_n = 1'b1;
    push_exp({4{7'h7F}});
    check_frame(1'b0);
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      din  = vt[v].din;
      load = 1'b1;
      push_exp(vt[v].segs);
      @(negedge clk);
      load = 1'b0;
      din  = 16'($urandom);
      chk($sformatf("pending_after_load v%0d", v), pending, 1);
      wait_tick();
      chk($sformatf("pending_at_tick v%0d", v), pending, 1);
      @(negedge clk);
      check_frame(1'b0);
      @(negedge clk);
    end

    // Two loads in one frame, then a load on the frame_tick cycle
    din  = 16'h1111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    din  = 16'h5678;
    load = 1'b1;
    push_exp(vt[1].segs);
    @(negedge clk);
    load = 1'b0;
    wait_tick();
    din  = 16'h9999;
    load = 1'b1;
    push_exp({4{7'b0000100}});
    @(negedge clk);
    load = 1'b0;
    din  = 16'h0000;
    check_frame(1'b1);
    chk("pending_before_second_commit", pending, 1);
    @(negedge clk);
    check_frame(1'b0);
    @(negedge clk);

    // Reset mid-ON with a pending load: outputs clear at once, shadow is dropped
    din  = 16'h4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_an", an, 4'b1110);
    chk("pre_reset_seg", seg, 7'b0000100);
    chk("pre_reset_pending", pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midon_reset_an", an, 4'hF);
    chk("midon_reset_seg", seg, 7'h7F);
    chk("midon_reset_pending", pending, 0);
    chk("midon_reset_frame_tick", frame_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp({4{7'h7F}});
    check_frame(1'b0);
    @(negedge clk);
    push_exp({4{7'h7F}});
    check_frame(1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
